// File: rtl/mini_src_mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, port IDs and the
// default RAM widths used by the RAM, the MAR/MDR and the port arbiter.
package mini_src_mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU
// memory path (port C) and the debug/program-loader port (port D).
module mem_port_arbiter
    import mini_src_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_wait,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_wait,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $fatal(1, "mem_port_arbiter: MEM_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    arb_state_t state, state_nxt;
    logic       last_gnt, gnt_nxt;
    logic       we_q;
    logic       capture;
    logic [2:0] lat_cnt;

    // last_gnt doubles as the current winner for the whole access.
    assign capture = (state == WAIT) && (lat_cnt == 3'd1);

    // Strobes decode straight from state so a reset drops them without a clock.
    assign mem_en = (state == ISSUE);
    assign mem_we = mem_en & we_q;
    assign c_wait = c_req & ~c_done;
    assign d_wait = d_req & ~d_done;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = last_gnt;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    state_nxt = ISSUE;
                    if (c_req && d_req) gnt_nxt = ~last_gnt;
                    else                gnt_nxt = d_req ? PORT_D : PORT_C;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            last_gnt <= PORT_D;
        end else begin
            state    <= state_nxt;
            last_gnt <= gnt_nxt;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_cnt   <= '0;
        end else begin
            if (state == IDLE && state_nxt == ISSUE) begin
                we_q      <= (gnt_nxt == PORT_D) ? d_we    : c_we;
                mem_addr  <= (gnt_nxt == PORT_D) ? d_addr  : c_addr;
                mem_wdata <= (gnt_nxt == PORT_D) ? d_wdata : c_wdata;
            end
            if (state == ISSUE)     lat_cnt <= LAT_INIT;
            else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            c_done  <= 1'b0;
            d_done  <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            c_done <= capture && (last_gnt == PORT_C);
            d_done <= capture && (last_gnt == PORT_D);
            if (capture && !we_q) begin
                if (last_gnt == PORT_D) d_rdata <= mem_rdata;
                else                    c_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1 behind a RAM model, one at MEM_LAT=4
// with mem_rdata driven cycle by cycle from the bench.
module tb_mem_port_arbiter;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;
    logic Reset;

    logic        c_req, c_we, c_done, c_wait, d_req, d_we, d_done, d_wait;
    logic [8:0]  c_addr, d_addr, mem_addr;
    logic [31:0] c_wdata, d_wdata, c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    logic        q_c_req, q_c_we, q_c_done, q_c_wait, q_d_req, q_d_we, q_d_done, q_d_wait;
    logic [8:0]  q_c_addr, q_d_addr, q_mem_addr;
    logic [31:0] q_c_wdata, q_d_wdata, q_c_rdata, q_d_rdata, q_mem_wdata, q_mem_rdata;
    logic        q_mem_en, q_mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .Clock(Clock), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_rdata(c_rdata), .c_wait(c_wait),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_wait(d_wait),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
        .Clock(Clock), .Reset(Reset),
        .c_req(q_c_req), .c_we(q_c_we), .c_addr(q_c_addr), .c_wdata(q_c_wdata),
        .c_done(q_c_done), .c_rdata(q_c_rdata), .c_wait(q_c_wait),
        .d_req(q_d_req), .d_we(q_d_we), .d_addr(q_d_addr), .d_wdata(q_d_wdata),
        .d_done(q_d_done), .d_rdata(q_d_rdata), .d_wait(q_d_wait),
        .mem_en(q_mem_en), .mem_we(q_mem_we), .mem_addr(q_mem_addr),
        .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata)
    );

    // One-cycle synchronous RAM model for the MEM_LAT=1 instance.
    logic [31:0] ram [512];
    logic        preload;
    int          wr_cnt = 0;
    int          bad_we = 0;

    always @(posedge Clock) begin
        if (preload) ram[9'h010] <= 32'hDEADBEEF;
        else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge Clock) if ((mem_we && !mem_en) || (q_mem_we && !q_mem_en)) bad_we <= bad_we + 1;

    int c_at[4], d_at[4], nc, nd;

    task automatic do_reset();
        c_req = 0; d_req = 0; q_c_req = 0; q_d_req = 0;
        Reset = 1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 0;
    endtask

    task automatic access1(input logic port, input logic we, input logic [8:0] addr,
                           input logic [31:0] wd, output int en_at, output int done_at,
                           output int we_cnt, output logic [8:0] a_seen,
                           output logic [31:0] w_seen, output logic wait1);
        en_at = -1; done_at = -1; we_cnt = 0; a_seen = '0; w_seen = '0; wait1 = 0;
        @(negedge Clock);
        if (port) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1; end
        else      begin c_we = we; c_addr = addr; c_wdata = wd; c_req = 1; end
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            @(negedge Clock);
            if (k == 1) wait1 = port ? d_wait : c_wait;
            if (mem_en && en_at < 0) begin en_at = k; a_seen = mem_addr; w_seen = mem_wdata; end
            if (mem_we) we_cnt++;
            if (port ? d_done : c_done) begin done_at = k; c_req = 0; d_req = 0; end
        end
        c_req = 0; d_req = 0;
    endtask

    // Both ports read (C from 0x010, D from 0x0FF); each port keeps req high until it
    // has collected its quota of done pulses.
    task automatic run_both(input int ncyc, input int c_max, input int d_max);
        nc = 0; nd = 0;
        for (int i = 0; i < 4; i++) begin c_at[i] = -1; d_at[i] = -1; end
        @(negedge Clock);
        c_we = 0; c_addr = 9'h010; d_we = 0; d_addr = 9'h0FF; c_req = 1; d_req = 1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clock);
            if (c_done && nc < 4) begin c_at[nc] = k; nc++; if (nc >= c_max) c_req = 0; end
            if (d_done && nd < 4) begin d_at[nd] = k; nd++; if (nd >= d_max) d_req = 0; end
        end
        c_req = 0; d_req = 0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got en=%b we=%b want 0 0", mem_en, mem_we); end
        checks++; if (c_done !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL reset_done: got c=%b d=%b want 0 0", c_done, d_done); end
        checks++; if (mem_addr !== 9'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
        checks++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got c=%h d=%h want 0 0", c_rdata, d_rdata); end
        checks++; if (q_mem_en !== 1'b0 || q_mem_we !== 1'b0 || q_c_done !== 1'b0 || q_d_done !== 1'b0) begin errors++; $display("FAIL reset_lat4_ctl: got en=%b we=%b cd=%b dd=%b want 0", q_mem_en, q_mem_we, q_c_done, q_d_done); end
        checks++; if (q_mem_addr !== 9'h0 || q_mem_wdata !== 32'h0 || q_c_rdata !== 32'h0 || q_d_rdata !== 32'h0) begin errors++; $display("FAIL reset_lat4_data: got nonzero register, want all 0"); end
        Reset = 0;
        @(negedge Clock);
        checks++; if (c_wait !== 1'b0 || d_wait !== 1'b0 || q_c_wait !== 1'b0 || q_d_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got c=%b d=%b want 0 0", c_wait, d_wait); end
    endtask

    task automatic test_single_read();
        int en_at, done_at, we_cnt; logic [8:0] a; logic [31:0] w; logic w1;
        access1(1'b0, 1'b0, 9'h010, 32'h0, en_at, done_at, we_cnt, a, w, w1);
        checks++; if (en_at != 1) begin errors++; $display("FAIL read_mem_en_cycle: got %0d want 1", en_at); end
        checks++; if (done_at != 3) begin errors++; $display("FAIL read_done_cycle: got %0d want 3", done_at); end
        checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", c_rdata); end
        checks++; if (a !== 9'h010) begin errors++; $display("FAIL read_mem_addr: got %h want 010", a); end
        checks++; if (w1 !== 1'b1) begin errors++; $display("FAIL read_c_wait: got %b want 1", w1); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL read_no_we: got %0d want 0", we_cnt); end
    endtask

    task automatic test_write_readback();
        int en_at, done_at, we_cnt, wr0; logic [8:0] a; logic [31:0] w; logic w1;
        access1(1'b1, 1'b0, 9'h010, 32'h0, en_at, done_at, we_cnt, a, w, w1);
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL d_read_rdata: got %h want deadbeef", d_rdata); end
        wr0 = wr_cnt;
        access1(1'b1, 1'b1, 9'h0FF, 32'h0000_1234, en_at, done_at, we_cnt, a, w, w1);
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL write_we_pulses: got %0d want 1", we_cnt); end
        checks++; if (done_at != 3) begin errors++; $display("FAIL write_done_cycle: got %0d want 3", done_at); end
        checks++; if (a !== 9'h0FF || w !== 32'h0000_1234) begin errors++; $display("FAIL write_mem_bus: got addr=%h data=%h want 0ff 00001234", a, w); end
        checks++; if (wr_cnt != wr0 + 1) begin errors++; $display("FAIL write_ram_count: got %0d want %0d", wr_cnt, wr0 + 1); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h want deadbeef", d_rdata); end
        access1(1'b0, 1'b0, 9'h0FF, 32'h0, en_at, done_at, we_cnt, a, w, w1);
        checks++; if (c_rdata !== 32'h0000_1234) begin errors++; $display("FAIL readback_rdata: got %h want 00001234", c_rdata); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_d_unchanged: got %h want deadbeef", d_rdata); end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        run_both(12, 2, 1);
        checks++; if (c_at[0] != 3) begin errors++; $display("FAIL tie_c_first: got %0d want 3", c_at[0]); end
        checks++; if (d_at[0] != 7) begin errors++; $display("FAIL tie_d_next: got %0d want 7", d_at[0]); end
        checks++; if (c_at[1] != 11) begin errors++; $display("FAIL tie_c_after_d: got %0d want 11", c_at[1]); end
        checks++; if (nc != 2 || nd != 1) begin errors++; $display("FAIL tie_counts: got c=%0d d=%0d want 2 1", nc, nd); end
        checks++; if (c_rdata !== 32'hDEADBEEF || d_rdata !== 32'h0000_1234) begin errors++; $display("FAIL tie_rdata: got c=%h d=%h want deadbeef 00001234", c_rdata, d_rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_both(16, 2, 2);
        checks++; if (c_at[0] != 3 || c_at[1] != 11) begin errors++; $display("FAIL b2b_c_slots: got %0d %0d want 3 11", c_at[0], c_at[1]); end
        checks++; if (d_at[0] != 7 || d_at[1] != 15) begin errors++; $display("FAIL b2b_d_slots: got %0d %0d want 7 15", d_at[0], d_at[1]); end
        checks++; if (nc != 2 || nd != 2) begin errors++; $display("FAIL b2b_counts: got c=%0d d=%0d want 2 2", nc, nd); end
    endtask

    task automatic test_lat4();
        int en_at = -1, done_at = -1;
        @(negedge Clock);
        q_c_we = 0; q_c_addr = 9'h033; q_c_req = 1; q_mem_rdata = 32'h1111_0000;
        for (int k = 1; k <= 12 && done_at < 0; k++) begin
            @(negedge Clock);
            q_mem_rdata = (k == 5) ? 32'hCAFE_F00D : 32'h1111_0000 + 32'(k);
            if (q_mem_en && en_at < 0) begin
                en_at = k;
                checks++; if (q_mem_addr !== 9'h033) begin errors++; $display("FAIL lat4_mem_addr: got %h want 033", q_mem_addr); end
            end
            if (q_c_done) begin done_at = k; q_c_req = 0; end
        end
        q_c_req = 0;
        checks++; if (en_at != 1) begin errors++; $display("FAIL lat4_mem_en_cycle: got %0d want 1", en_at); end
        checks++; if (done_at != 6) begin errors++; $display("FAIL lat4_done_cycle: got %0d want 6", done_at); end
        checks++; if (q_c_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat4_rdata: got %h want cafef00d", q_c_rdata); end
        repeat (3) @(negedge Clock);
        checks++; if (q_c_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat4_rdata_hold: got %h want cafef00d", q_c_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int wr0, dones;
        @(negedge Clock);
        c_we = 1; c_addr = 9'h020; c_wdata = 32'h5555_5555; c_req = 1;
        @(negedge Clock);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL abort_issue_strobe: got en=%b we=%b want 1 1", mem_en, mem_we); end
        wr0 = wr_cnt;
        Reset = 1;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL abort_async_drop: got en=%b we=%b want 0 0", mem_en, mem_we); end
        c_req = 0;
        @(negedge Clock);
        Reset = 0;
        checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL abort_no_write: got %0d want %0d", wr_cnt, wr0); end
        // Second abort lands in WAIT, with C holding the grant.
        @(negedge Clock);
        c_req = 1;
        repeat (2) @(negedge Clock);
        Reset = 1; c_req = 0;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL abort_wait_strobe: got en=%b we=%b want 0 0", mem_en, mem_we); end
        dones = 0;
        @(negedge Clock);
        Reset = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            if (c_done || d_done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        run_both(8, 1, 1);
        checks++; if (c_at[0] != 3 || d_at[0] != 7) begin errors++; $display("FAIL abort_gnt_reset: got c=%0d d=%0d want 3 7", c_at[0], d_at[0]); end
    endtask

    initial begin
        Reset = 1; preload = 1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        q_c_req = 0; q_c_we = 0; q_c_addr = '0; q_c_wdata = '0;
        q_d_req = 0; q_d_we = 0; q_d_addr = '0; q_d_wdata = '0;
        q_mem_rdata = '0;
        @(posedge Clock);
        #1 preload = 0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_tie_after_reset();
        test_back_to_back();
        test_lat4();
        test_reset_mid_access();
        checks++; if (bad_we != 0) begin errors++; $display("FAIL we_outside_en: got %0d want 0", bad_we); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
